// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: segment encodings,
// the active-low hex digit table and the settle FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry i is the active-low {g,f,e,d,c,b,a} pattern for hex digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_LOCK
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of one active-low digit pattern into a nibble,
// flagging whether the pattern is a known digit or the all-off blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_capture.sv
// Receives a two-digit seven-segment bus, accepts only patterns that stay
// stable for STABLE_CYCLES samples, and decodes them back to a byte.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int UPD_W         = 8
) (
  input  logic             clk100_i,
  input  logic             rstn_i,
  input  logic [6:0]       hex0_i,
  input  logic [6:0]       hex1_i,
  input  logic             clr_i,
  output logic [7:0]       byte_o,
  output logic             valid_o,
  output logic             blank_o,
  output logic             update_o,
  output logic             err_o,
  output logic [UPD_W-1:0] upd_cnt_o,
  output logic [UPD_W-1:0] err_cnt_o
);

  localparam logic [7:0]       STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [UPD_W-1:0] CNT_MAX    = '1;

  logic [13:0] in_q;
  logic [13:0] cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic        accept;

  logic       legal0, legal1, blank0, blank1;
  logic [3:0] nib0, nib1;
  logic [7:0] new_byte;

  seg7_decode u_dec0 (
    .seg    (in_q[6:0]),
    .legal  (legal0),
    .blank  (blank0),
    .nibble (nib0)
  );

  seg7_decode u_dec1 (
    .seg    (in_q[13:7]),
    .legal  (legal1),
    .blank  (blank1),
    .nibble (nib1)
  );

  assign new_byte = {nib1, nib0};

  // in_q resets to the all-blank pair so an idle bus never starts a settle.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_q    <= 14'h3FFF;
      cand_q  <= 14'h3FFF;
      cnt_q   <= 8'd0;
      state_q <= S_IDLE;
    end else begin
      in_q    <= {hex1_i, hex0_i};
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Any change reloads the candidate; with STABLE_CYCLES=1 the reload itself accepts.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (in_q != cand_q) begin
      cand_d = in_q;
      cnt_d  = 8'd1;
      if (STABLE_CYCLES == 1) begin
        accept  = 1'b1;
        state_d = S_LOCK;
      end else begin
        state_d = S_SETTLE;
      end
    end else begin
      case (state_q)
        S_SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == STABLE_LIM) begin
            accept  = 1'b1;
            state_d = S_LOCK;
          end
        end
        default: ;
      endcase
    end
  end

  // clr_i is applied last so it wins over an increment in the same cycle.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_o    <= 8'h00;
      valid_o   <= 1'b0;
      blank_o   <= 1'b0;
      update_o  <= 1'b0;
      err_o     <= 1'b0;
      upd_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      update_o <= 1'b0;
      if (accept) begin
        if (legal0 && legal1) begin
          byte_o  <= new_byte;
          valid_o <= 1'b1;
          blank_o <= 1'b0;
          if (!valid_o || (new_byte != byte_o)) begin
            update_o <= 1'b1;
            if (upd_cnt_o != CNT_MAX) upd_cnt_o <= upd_cnt_o + 1'b1;
          end
        end else if (blank0 && blank1) begin
          blank_o <= 1'b1;
          valid_o <= 1'b0;
        end else begin
          err_o <= 1'b1;
          if (err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + 1'b1;
        end
      end
      if (clr_i) begin
        upd_cnt_o <= '0;
        err_cnt_o <= '0;
        err_o     <= 1'b0;
      end
    end
  end

endmodule
